load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_lane.sv | 60 ++++++
 rtl/load_store_unit.sv | 123 ++++++++++++
 tb/tb_load_store_unit.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// size-to-byte-count constants and the alignment rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'b00,
    SIZE_HALF   = 2'b01,
    SIZE_WORD   = 2'b10,
    SIZE_DOUBLE = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_READ,
    WRITE,
    RESP
  } lsu_state_e;

  localparam logic [3:0] BYTES_BYTE   = 4'd1;
  localparam logic [3:0] BYTES_HALF   = 4'd2;
  localparam logic [3:0] BYTES_WORD   = 4'd4;
  localparam logic [3:0] BYTES_DOUBLE = 4'd8;

  function automatic logic [3:0] size_bytes(input lsu_size_e size);
    case (size)
      SIZE_BYTE: return BYTES_BYTE;
      SIZE_HALF: return BYTES_HALF;
      SIZE_WORD: return BYTES_WORD;
      default:   return BYTES_DOUBLE;
    endcase
  endfunction

  // An access is aligned when the low address bits are a multiple of its byte count.
  function automatic logic is_misaligned(input lsu_size_e size, input logic [2:0] addr_lo);
    logic [3:0] lo_mask;
    lo_mask = size_bytes(size) - 4'd1;
    return (addr_lo & lo_mask[2:0]) != 3'b000;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane handling: extracts and extends a load lane from a 64-bit
// word, and merges a store lane into a previously read word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [63:0] rd_word,
  input  logic [63:0] base_word,
  input  logic [63:0] wdata,
  input  logic [2:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] load_data,
  output logic [63:0] merged_data
);

  logic [5:0]         shamt;
  logic [63:0]        shifted;
  logic [63:0]        lane_mask;
  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;
  logic signed [31:0] lane_w;

  assign shamt = {addr_lo, 3'b000};

  // Shift the addressed lane down to bit 0, then zero- or sign-extend it.
  always_comb begin
    shifted   = rd_word >> shamt;
    lane_b    = shifted[7:0];
    lane_h    = shifted[15:0];
    lane_w    = shifted[31:0];
    load_data = rd_word;
    case (lsu_size_e'(size))
      SIZE_BYTE: begin
        if (is_unsigned) load_data = {56'd0, shifted[7:0]};
        else             load_data = 64'(lane_b);
      end
      SIZE_HALF: begin
        if (is_unsigned) load_data = {48'd0, shifted[15:0]};
        else             load_data = 64'(lane_h);
      end
      SIZE_WORD: begin
        if (is_unsigned) load_data = {32'd0, shifted[31:0]};
        else             load_data = 64'(lane_w);
      end
      default: load_data = rd_word;
    endcase
  end

  // Replace only the target lane of the captured word with the store data.
  always_comb begin
    case (lsu_size_e'(size))
      SIZE_BYTE: lane_mask = 64'h0000_0000_0000_00FF;
      SIZE_HALF: lane_mask = 64'h0000_0000_0000_FFFF;
      SIZE_WORD: lane_mask = 64'h0000_0000_FFFF_FFFF;
      default:   lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    merged_data = (base_word & ~(lane_mask << shamt)) | ((wdata & lane_mask) << shamt);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one access at a time, checks alignment and ROM
// protection, and performs loads, full-word stores and read-modify-write
// sub-word stores against a 64-bit word memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int rom_size = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wr_data,
  output logic        mem_wr_enable,
  output logic        mem_rd_enable,
  input  logic [63:0] mem_rd_data
);

  localparam logic [28:0] ROM_WORDS = 29'(rom_size);

  lsu_state_e  state;
  logic        we_q;
  logic        uns_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] cap_q;
  logic [63:0] rdata_q;
  logic [1:0]  size_q;

  logic        req_err;
  logic        mem_active;
  logic [63:0] load_data;
  logic [63:0] merged_data;

  assign req_err = is_misaligned(lsu_size_e'(req_size), req_addr[2:0]) ||
                   (req_we && (req_addr[31:3] < ROM_WORDS));

  lsu_lane u_lane (
    .rd_word     (mem_rd_data),
    .base_word   (cap_q),
    .wdata       (wdata_q),
    .addr_lo     (addr_q[2:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .merged_data (merged_data)
  );

  // Access sequencer: latch the request on accept, then walk the memory phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 64'd0;
      size_q  <= 2'b00;
      cap_q   <= 64'd0;
      rdata_q <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            err_q   <= req_err;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            cap_q   <= 64'd0;
            rdata_q <= 64'd0;
            if (req_err)                       state <= RESP;
            else if (!req_we)                  state <= LOAD;
            else if (req_size == SIZE_DOUBLE)  state <= WRITE;
            else                               state <= RMW_READ;
          end
        end
        LOAD: begin
          rdata_q <= load_data;
          state   <= RESP;
        end
        RMW_READ: begin
          cap_q <= mem_rd_data;
          state <= WRITE;
        end
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake, response and memory strobes decoded from the registered state.
  always_comb begin
    mem_active    = (state == LOAD) || (state == RMW_READ) || (state == WRITE);
    req_ready     = (state == IDLE);
    resp_valid    = (state == RESP);
    resp_err      = resp_valid && err_q;
    resp_rdata    = resp_valid ? rdata_q : 64'd0;
    mem_rd_enable = (state == LOAD) || (state == RMW_READ);
    // Reset must gate the write strobe immediately so an interrupted WRITE commits nothing.
    mem_wr_enable = (state == WRITE) && !rst;
    mem_addr      = mem_active ? {addr_q[31:3], 3'b000} : 32'd0;
    mem_wr_data   = 64'd0;
    if (state == WRITE) begin
      mem_wr_data = (size_q == SIZE_DOUBLE) ? wdata_q : merged_data;
    end
    // we_q is kept for visibility of the accepted request; routing is fixed at accept.
    if (we_q && (state == LOAD)) mem_addr = mem_addr;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-level reference model.
module tb_load_store_unit;

  localparam int ROM = 16;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [63:0] mem_wr_data;
  logic        mem_wr_enable;
  logic        mem_rd_enable;
  logic [63:0] mem_rd_data;

  int checks;
  int errors;
  logic        mem_init;
  logic [63:0] mem [64];
  logic [63:0] ref_mem [64];
  int rd_total;
  int wr_total;

  load_store_unit #(.rom_size(ROM)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_enable (mem_wr_enable),
    .mem_rd_enable (mem_rd_enable),
    .mem_rd_data   (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input int i);
    if (i == 16) return 64'h1122334455667788;
    return 64'h0123456789ABCDEF ^ (64'(i) * 64'h9E3779B97F4A7C15);
  endfunction

  // Memory array and strobe activity counters.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      rd_total <= 0;
      wr_total <= 0;
    end else begin
      if (mem_wr_enable) mem[mem_addr[8:3]] <= mem_wr_data;
      if (mem_rd_enable) rd_total <= rd_total + 1;
      if (mem_wr_enable) wr_total <= wr_total + 1;
    end
  end

  assign mem_rd_data = mem[mem_addr[8:3]];

  // Reference model
  function automatic logic ref_err(input logic we, input logic [31:0] addr, input logic [1:0] size);
    int nb;
    nb = 1 << size;
    return ((int'(addr[2:0]) % nb) != 0) || (we && (int'(addr[31:3]) < ROM));
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] word, input int off,
                                           input logic [1:0] size, input logic uns);
    logic [63:0] v;
    int nb;
    nb = 1 << size;
    v = 64'd0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
    if (!uns && nb < 8 && v[8*nb-1]) begin
      for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  function automatic logic [63:0] ref_store(input logic [63:0] word, input int off,
                                            input logic [1:0] size, input logic [63:0] wdata);
    logic [63:0] v;
    int nb;
    nb = 1 << size;
    v = word;
    for (int i = 0; i < nb; i++) v[8*(off+i) +: 8] = wdata[8*i +: 8];
    return v;
  endfunction

  // Issue one request from IDLE and observe its response (bounded wait).
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                        input logic [1:0] size, input logic uns,
                        output int lat, output logic [63:0] rdata, output logic err,
                        output int nrd, output int nwr);
    int rd0, wr0;
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    req_valid    = 1'b1;
    rd0 = rd_total;
    wr0 = wr_total;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    nrd   = rd_total - rd0;
    nwr   = wr_total - wr0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_rd_enable, mem_wr_enable} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 10000",
               {req_ready, resp_valid, resp_err, mem_rd_enable, mem_wr_enable});
    end
    checks++;
    if (resp_rdata !== 64'd0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata);
    end
    checks++;
    if (mem_wr_data !== 64'd0) begin
      errors++; $display("FAIL reset_wr_data: got %h expected 0", mem_wr_data);
    end
    checks++;
    if (mem_addr !== 32'd0) begin
      errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr);
    end
  endtask

  task automatic test_load_byte();
    int lat, nrd, nwr; logic [63:0] rd; logic err;
    do_txn(1'b0, 32'h80, 64'd0, 2'b00, 1'b0, lat, rd, err, nrd, nwr);
    checks++;
    if (rd !== 64'hFFFFFFFFFFFFFF88) begin
      errors++; $display("FAIL lb_signed_data: got %h expected ffffffffffffff88", rd);
    end
    checks++;
    if (err !== 1'b0 || lat != 2) begin
      errors++; $display("FAIL lb_signed_err_lat: got err=%b lat=%0d expected err=0 lat=2", err, lat);
    end
    do_txn(1'b0, 32'h80, 64'd0, 2'b00, 1'b1, lat, rd, err, nrd, nwr);
    checks++;
    if (rd !== 64'h0000000000000088) begin
      errors++; $display("FAIL lb_unsigned_data: got %h expected 0000000000000088", rd);
    end
  endtask

  task automatic test_store_half();
    int lat, nrd, nwr; logic [63:0] rd; logic err;
    do_txn(1'b1, 32'h82, 64'hBEEF, 2'b01, 1'b0, lat, rd, err, nrd, nwr);
    ref_mem[16] = 64'h11223344BEEF7788;
    checks++;
    if (lat != 3 || err !== 1'b0 || rd !== 64'd0) begin
      errors++; $display("FAIL sh_resp: got lat=%0d err=%b rdata=%h expected lat=3 err=0 rdata=0", lat, err, rd);
    end
    checks++;
    if (mem[16] !== 64'h11223344BEEF7788) begin
      errors++; $display("FAIL sh_word: got %h expected 11223344beef7788", mem[16]);
    end
  endtask

  task automatic test_misaligned();
    int lat, nrd, nwr; logic [63:0] rd; logic err;
    do_txn(1'b0, 32'h82, 64'd0, 2'b10, 1'b0, lat, rd, err, nrd, nwr);
    checks++;
    if (err !== 1'b1 || lat != 1 || rd !== 64'd0) begin
      errors++; $display("FAIL lw_misaligned: got err=%b lat=%0d rdata=%h expected err=1 lat=1 rdata=0", err, lat, rd);
    end
    checks++;
    if (nrd != 0 || nwr != 0) begin
      errors++; $display("FAIL lw_misaligned_strobes: got rd=%0d wr=%0d expected 0 0", nrd, nwr);
    end
  endtask

  task automatic test_rom_write();
    int lat, nrd, nwr; logic [63:0] rd; logic err;
    do_txn(1'b1, 32'h08, {$urandom, $urandom}, 2'b11, 1'b0, lat, rd, err, nrd, nwr);
    checks++;
    if (err !== 1'b1 || lat != 1) begin
      errors++; $display("FAIL sd_rom_err: got err=%b lat=%0d expected err=1 lat=1", err, lat);
    end
    checks++;
    if (nwr != 0 || nrd != 0) begin
      errors++; $display("FAIL sd_rom_strobes: got rd=%0d wr=%0d expected 0 0", nrd, nwr);
    end
    checks++;
    if (mem[1] !== ref_mem[1]) begin
      errors++; $display("FAIL sd_rom_word: got %h expected %h", mem[1], ref_mem[1]);
    end
  endtask

  task automatic test_reset_during_rmw();
    int wr0;
    req_we = 1'b1; req_addr = 32'h80; req_wdata = 64'hAA; req_size = 2'b00; req_unsigned = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_rd_enable !== 1'b1) begin
      errors++; $display("FAIL rmw_read_phase: got rd_en=%b expected 1", mem_rd_enable);
    end
    wr0 = wr_total;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_wr_enable !== 1'b0) begin
      errors++; $display("FAIL rmw_reset_state: got ready=%b resp=%b wr_en=%b expected 1 0 0",
                         req_ready, resp_valid, mem_wr_enable);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_total != wr0 || mem[16] !== ref_mem[16] || req_ready !== 1'b1) begin
      errors++; $display("FAIL rmw_reset_nowrite: got writes=%0d word=%h ready=%b expected 0 %h 1",
                         wr_total - wr0, mem[16], req_ready, ref_mem[16]);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] wd;
    wd = {$urandom, $urandom};
    req_we = 1'b0; req_addr = 32'h80; req_wdata = 64'd0; req_size = 2'b11; req_unsigned = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_busy_load: got ready=%b expected 0", req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== ref_mem[16]) begin
      errors++; $display("FAIL b2b_resp_a: got valid=%b ready=%b rdata=%h expected 1 0 %h",
                         resp_valid, req_ready, resp_rdata, ref_mem[16]);
    end
    req_we = 1'b1; req_addr = 32'h100; req_wdata = wd;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got ready=%b valid=%b expected 1 0", req_ready, resp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || mem_wr_enable !== 1'b1 || mem_wr_data !== wd) begin
      errors++; $display("FAIL b2b_write_b: got ready=%b wr_en=%b wr_data=%h expected 0 1 %h",
                         req_ready, mem_wr_enable, mem_wr_data, wd);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin
      errors++; $display("FAIL b2b_resp_b: got valid=%b err=%b expected 1 0", resp_valid, resp_err);
    end
    @(posedge clk); #1;
    ref_mem[32] = wd;
    checks++;
    if (mem[32] !== wd) begin
      errors++; $display("FAIL b2b_word: got %h expected %h", mem[32], wd);
    end
  endtask

  task automatic test_random();
    int lat, nrd, nwr, idx, off, nb, e_lat, e_rd, e_wr;
    logic [63:0] rd, wd, e_rdata;
    logic err, we, uns, e_err;
    logic [1:0] size;
    logic [31:0] addr;
    for (int n = 0; n < 300; n++) begin
      we   = 1'($urandom % 2);
      uns  = 1'($urandom % 2);
      size = 2'($urandom % 4);
      nb   = 1 << size;
      off  = int'($urandom % 8);
      if ($urandom % 4 != 0) off = off - (off % nb);
      idx  = int'($urandom % 64);
      addr = 32'(idx * 8 + off);
      wd   = {$urandom, $urandom};
      e_err   = ref_err(we, addr, size);
      e_lat   = e_err ? 1 : ((!we || size == 2'b11) ? 2 : 3);
      e_rd    = e_err ? 0 : ((!we || size != 2'b11) ? 1 : 0);
      e_wr    = (!e_err && we) ? 1 : 0;
      e_rdata = (!e_err && !we) ? ref_load(ref_mem[idx], off, size, uns) : 64'd0;
      if (!e_err && we) ref_mem[idx] = ref_store(ref_mem[idx], off, size, wd);
      do_txn(we, addr, wd, size, uns, lat, rd, err, nrd, nwr);
      checks++;
      if (rd !== e_rdata || err !== e_err || lat != e_lat) begin
        errors++;
        $display("FAIL rnd_resp[%0d] we=%b addr=%h size=%0d: got rdata=%h err=%b lat=%0d expected %h %b %0d",
                 n, we, addr, size, rd, err, lat, e_rdata, e_err, e_lat);
      end
      checks++;
      if (nrd != e_rd || nwr != e_wr) begin
        errors++; $display("FAIL rnd_strobes[%0d]: got rd=%0d wr=%0d expected %0d %0d", n, nrd, nwr, e_rd, e_wr);
      end
      checks++;
      if (mem[idx] !== ref_mem[idx] || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL rnd_after[%0d]: got word=%h valid=%b ready=%b expected %h 0 1",
                           n, mem[idx], resp_valid, req_ready, ref_mem[idx]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    mem_init = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = 32'd0;
    req_wdata = 64'd0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_rom_write();
    test_reset_during_rmw();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
